mem_stage: RTL

- Pipeline stage directly downstream of the execute stage. Latches the 174-bit execute-to-memory bus and collects data_sram_rdata for the load issued by execute in the previous cycle.
- Performs load byte/halfword extraction and sign/zero extension, and detects load address misalignment (ALE).
- Drives the 169-bit memory-to-writeback bus and the mem_ex flag back to execute.

---
 rtl/mem_stage.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory pipeline stage: latches the execute bus, extracts and extends load data, flags ALE.
// Optional MEM_FWD_EN adds a forwarding bus and a load indicator for the decode bypass network.
module mem_stage #(
  parameter int ES_BUS_W = 174,
  parameter int WS_BUS_W = 169
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ws_allowin,
  output logic                ms_allowin,
  input  logic                es_to_ms_valid,
  input  logic [ES_BUS_W-1:0] es_to_ms_bus,
  input  logic [31:0]         data_sram_rdata,
  output logic                ms_to_ws_valid,
  output logic [WS_BUS_W-1:0] ms_to_ws_bus,
  output logic                mem_ex,
  output logic                out_ms_valid,
  input  logic                wb_ex,
  input  logic                wb_ertn
`ifdef MEM_FWD_EN
  ,
  output logic [37:0]         ms_fwd_bus,
  output logic                ms_is_load
`endif
);

  logic                ms_valid_q;
  logic                ms_valid_d;
  logic [ES_BUS_W-1:0] es_bus_q;
  logic [ES_BUS_W-1:0] es_bus_d;
  logic [31:0]         rdata_buf_q;
  logic [31:0]         rdata_buf_d;
  logic                rdata_buf_valid_q;
  logic                rdata_buf_valid_d;

  logic        ms_ready_go;
  logic        flush;
  logic [31:0] rj;
  logic [31:0] rkd;
  logic [33:0] csr_data;
  logic [4:0]  ld_op;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] result;
  logic [31:0] pc;
  logic        ld_b;
  logic        ld_h;
  logic        ld_w;
  logic        ld_bu;
  logic        ld_hu;
  logic [1:0]  addr_lo;
  logic [31:0] rdata;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_value;
  logic [31:0] final_result;
  logic        ale;
  logic        gr_we_q;

  assign ms_ready_go    = 1'b1;
  assign flush          = wb_ex | wb_ertn;
  assign ms_allowin     = !ms_valid_q | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid_q & ms_ready_go;
  assign out_ms_valid   = ms_valid_q;

  assign {rj, rkd, csr_data, ld_op, res_from_mem, gr_we, dest, result, pc} = es_bus_q;
  assign {ld_b, ld_h, ld_w, ld_bu, ld_hu} = ld_op;
  assign addr_lo = result[1:0];

  always_comb begin
    ms_valid_d = ms_valid_q;
    if (flush) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end
  end

  assign es_bus_d = (es_to_ms_valid && ms_allowin) ? es_to_ms_bus : es_bus_q;

  // The SRAM output moves on as soon as execute issues its next address, so a
  // stalled entry must hold its data from the first valid cycle onward.
  always_comb begin
    rdata_buf_d       = rdata_buf_q;
    rdata_buf_valid_d = rdata_buf_valid_q;
    if (flush || (ms_valid_q && ws_allowin)) begin
      rdata_buf_valid_d = 1'b0;
    end else if (ms_valid_q && !ws_allowin && !rdata_buf_valid_q) begin
      rdata_buf_d       = data_sram_rdata;
      rdata_buf_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q        <= 1'b0;
      rdata_buf_valid_q <= 1'b0;
    end else begin
      ms_valid_q        <= ms_valid_d;
      rdata_buf_valid_q <= rdata_buf_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    es_bus_q    <= es_bus_d;
    rdata_buf_q <= rdata_buf_d;
  end

  assign rdata = rdata_buf_valid_q ? rdata_buf_q : data_sram_rdata;

  always_comb begin
    load_byte = rdata[7:0];
    case (addr_lo)
      2'd0: load_byte = rdata[7:0];
      2'd1: load_byte = rdata[15:8];
      2'd2: load_byte = rdata[23:16];
      2'd3: load_byte = rdata[31:24];
      default: load_byte = rdata[7:0];
    endcase
  end

  assign load_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_value = rdata;
    if (ld_b) begin
      load_value = {{24{load_byte[7]}}, load_byte};
    end else if (ld_bu) begin
      load_value = {24'd0, load_byte};
    end else if (ld_h) begin
      load_value = {{16{load_half[15]}}, load_half};
    end else if (ld_hu) begin
      load_value = {16'd0, load_half};
    end
  end

  assign final_result = res_from_mem ? load_value : result;

  assign ale     = (ld_w & (addr_lo != 2'd0)) | ((ld_h | ld_hu) & addr_lo[0]);
  assign gr_we_q = gr_we & !ale;
  assign mem_ex  = ms_valid_q & (csr_data[33] | ale);

  assign ms_to_ws_bus = {rj, rkd, csr_data, ale, gr_we_q, dest, final_result, pc};

`ifdef MEM_FWD_EN
  assign ms_fwd_bus = {ms_valid_q & gr_we_q, dest, final_result};
  assign ms_is_load = ms_valid_q & res_from_mem;
`endif

endmodule
